// File: rtl/ctr_pkg.sv
// Shared types and helpers for the AES-CTR sequencer: FSM state encoding,
// block geometry, and the counter-block builder.
package ctr_pkg;

   localparam int BLK_W      = 128;
   localparam int BLK_STRIDE = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      PUSH  = 2'd3
   } state_t;

   // Adds cnt into the low ctr_w bits of the nonce; no carry escapes into the upper bits.
   function automatic logic [BLK_W-1:0] build_ctr_block(
      input logic [BLK_W-1:0] nonce,
      input logic [BLK_W-1:0] cnt,
      input int               ctr_w
   );
      logic [BLK_W-1:0] low_mask;
      low_mask = (ctr_w >= BLK_W) ? '1 : ((BLK_W'(1) << ctr_w) - BLK_W'(1));
      return (nonce & ~low_mask) | ((nonce + cnt) & low_mask);
   endfunction

endpackage

// File: rtl/ctr_block_gen.sv
// Block counter, configuration change detect, and counter-block/address generation.
// CTR_WRAP_CHECK_EN adds a sticky flag raised when a push consumes the last counter value.
module ctr_block_gen
   import ctr_pkg::*;
#(
   parameter int AHB_BUS_SIZE = 32,
   parameter int CTR_W        = 32
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    accept,
   input  logic                    advance,
   input  logic [BLK_W-1:0]        key_in,
   input  logic [BLK_W-1:0]        nonce_in,
   input  logic [AHB_BUS_SIZE-1:0] dest_in,
   input  logic [BLK_W-1:0]        key_q,
   input  logic [BLK_W-1:0]        nonce_q,
   input  logic [AHB_BUS_SIZE-1:0] dest_q,
   output logic [BLK_W-1:0]        ctr_block,
   output logic [AHB_BUS_SIZE-1:0] blk_addr,
   output logic                    wrap_err
);

   logic [CTR_W-1:0] cnt_reg;
   logic [CTR_W-1:0] cnt_next;
   logic             cfg_changed;

   // A new key, nonce or destination starts a fresh stream at counter 0.
   assign cfg_changed = (key_in != key_q) || (nonce_in != nonce_q) || (dest_in != dest_q);

   always_comb begin
      cnt_next = cnt_reg;
      if (accept && cfg_changed) begin
         cnt_next = '0;
      end else if (advance) begin
         cnt_next = cnt_reg + CTR_W'(1);
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign ctr_block = build_ctr_block(nonce_q, BLK_W'(cnt_reg), CTR_W);
   assign blk_addr  = dest_q + AHB_BUS_SIZE'(cnt_reg) * AHB_BUS_SIZE'(BLK_STRIDE);

`ifdef CTR_WRAP_CHECK_EN
   logic err_reg;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         err_reg <= 1'b0;
      end else if (advance && (&cnt_reg)) begin
         err_reg <= 1'b1;
      end
   end

   assign wrap_err = err_reg;
`else
   assign wrap_err = 1'b0;
`endif

endmodule

// File: rtl/ctr_sequencer.sv
// AES-CTR sequencer: latches one block, runs the AES core on the counter block and
// pushes ciphertext with its address into the output FIFO. Optional CTR_WRAP_CHECK_EN.
module ctr_sequencer #(
   parameter int AHB_BUS_SIZE = 32,
   parameter int BLK_W        = 128,
   parameter int CTR_W        = 32
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    write_out,
   input  logic [BLK_W-1:0]        key,
   input  logic [BLK_W-1:0]        nonce,
   input  logic [AHB_BUS_SIZE-1:0] destination,
   input  logic [BLK_W-1:0]        plain_text,
   output logic                    ctrl_ready,
   output logic                    ctrl_overrun,
   output logic                    aes_start,
   output logic [BLK_W-1:0]        aes_key,
   output logic [BLK_W-1:0]        aes_block_in,
   input  logic                    aes_done,
   input  logic [BLK_W-1:0]        aes_block_out,
   input  logic                    fifo_full,
   output logic                    fifo_push,
   output logic [BLK_W-1:0]        fifo_data,
   output logic [AHB_BUS_SIZE-1:0] fifo_addr,
   output logic                    ctr_error
);
   import ctr_pkg::*;

   localparam int N_WORDS = BLK_W / 32;

   state_t                  state_reg, state_next;
   logic [BLK_W-1:0]        key_reg, nonce_reg, pt_reg, fifo_data_reg, ct_word;
   logic [AHB_BUS_SIZE-1:0] dest_reg;
   logic                    overrun_reg;
   logic                    accept, advance, wrap_err;

   assign ctrl_ready = (state_reg == IDLE) && !wrap_err;
   assign accept     = ctrl_ready && write_out;
   assign advance    = (state_reg == PUSH) && !fifo_full;

   ctr_block_gen #(
      .AHB_BUS_SIZE(AHB_BUS_SIZE),
      .CTR_W       (CTR_W)
   ) u_block_gen (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .accept   (accept),
      .advance  (advance),
      .key_in   (key),
      .nonce_in (nonce),
      .dest_in  (destination),
      .key_q    (key_reg),
      .nonce_q  (nonce_reg),
      .dest_q   (dest_reg),
      .ctr_block(aes_block_in),
      .blk_addr (fifo_addr),
      .wrap_err (wrap_err)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_WORDS; gi++) begin : g_xor
         assign ct_word[gi*32 +: 32] = aes_block_out[gi*32 +: 32] ^ pt_reg[gi*32 +: 32];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      aes_start  = 1'b0;
      fifo_push  = 1'b0;
      case (state_reg)
         IDLE:  if (accept) state_next = START;
         START: begin
            aes_start  = 1'b1;
            state_next = WAIT;
         end
         WAIT:  if (aes_done) state_next = PUSH;
         PUSH: begin
            fifo_push = !fifo_full;
            if (!fifo_full) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_reg     <= IDLE;
         key_reg       <= '0;
         nonce_reg     <= '0;
         dest_reg      <= '0;
         pt_reg        <= '0;
         fifo_data_reg <= '0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         // Any write_out not taken (busy or counter exhausted) is reported as overrun.
         overrun_reg <= write_out && !accept;
         if (accept) begin
            key_reg   <= key;
            nonce_reg <= nonce;
            dest_reg  <= destination;
            pt_reg    <= plain_text;
         end
         if ((state_reg == WAIT) && aes_done) begin
            fifo_data_reg <= ct_word;
         end
      end
   end

   assign aes_key      = key_reg;
   assign fifo_data    = fifo_data_reg;
   assign ctrl_overrun = overrun_reg;
   assign ctr_error    = wrap_err;

endmodule

// File: tb/tb_ctr_sequencer.sv
// Directed and randomized bench for ctr_sequencer with a narrow counter (CTR_W=2) so
// wrap behaviour is reachable; expectations come from a stream-level reference model.
module tb_ctr_sequencer;

   localparam int TB_CTR_W = 2;

   logic         tb_HCLK = 1'b0;
   logic         HRESETn;
   logic         write_out;
   logic [127:0] key, nonce, plain_text, aes_key, aes_block_in, aes_block_out, fifo_data;
   logic [31:0]  destination, fifo_addr;
   logic         ctrl_ready, ctrl_overrun, aes_start, aes_done, fifo_full, fifo_push, ctr_error;

   always #5 tb_HCLK = ~tb_HCLK;

   ctr_sequencer #(
      .AHB_BUS_SIZE(32),
      .BLK_W       (128),
      .CTR_W       (TB_CTR_W)
   ) dut (
      .HCLK         (tb_HCLK),
      .HRESETn      (HRESETn),
      .write_out    (write_out),
      .key          (key),
      .nonce        (nonce),
      .destination  (destination),
      .plain_text   (plain_text),
      .ctrl_ready   (ctrl_ready),
      .ctrl_overrun (ctrl_overrun),
      .aes_start    (aes_start),
      .aes_key      (aes_key),
      .aes_block_in (aes_block_in),
      .aes_done     (aes_done),
      .aes_block_out(aes_block_out),
      .fifo_full    (fifo_full),
      .fifo_push    (fifo_push),
      .fifo_data    (fifo_data),
      .fifo_addr    (fifo_addr),
      .ctr_error    (ctr_error)
   );

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: current stream configuration, blocks consumed, error flag, last ciphertext.
   logic [127:0] m_key, m_nonce, m_data;
   logic [31:0]  m_dest;
   int           m_n;
   bit           m_err;

   logic [127:0] cfg_key   [3];
   logic [127:0] cfg_nonce [3];
   logic [31:0]  cfg_dest  [3];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_HCLK);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] exp_block(input logic [127:0] nc, input int n);
      logic [127:0] mask, low;
      mask = (128'd1 << TB_CTR_W) - 128'd1;
      low  = nc & mask;
      return (nc - low) + ((low + 128'(n)) & mask);
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] d, input int n);
      return d + 32'(n * 16);
   endfunction

   task automatic model_reset();
      m_key = '0; m_nonce = '0; m_dest = '0; m_data = '0; m_n = 0; m_err = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   ctrl_ready,   1);
      check({tag, "_start"},   aes_start,    0);
      check({tag, "_push"},    fifo_push,    0);
      check({tag, "_overrun"}, ctrl_overrun, 0);
      check({tag, "_err"},     ctr_error,    0);
      check({tag, "_data"},    fifo_data,    0);
      check({tag, "_addr"},    fifo_addr,    0);
      check({tag, "_key"},     aes_key,      0);
      check({tag, "_blkin"},   aes_block_in, 0);
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      model_reset();
      check_reset_outputs("rst");
      $display("reset applied");
   endtask

   task automatic run_block(input logic [127:0] k, input logic [127:0] nc, input logic [31:0] d,
                            input logic [127:0] pt, input int lat, input int full_cyc,
                            input bit inject, input logic [127:0] ks);
      logic [127:0] eblk, edata;
      logic [31:0]  eaddr;
      key = k; nonce = nc; destination = d; plain_text = pt;
      if (m_err) begin
         check("drop_ready_pre", ctrl_ready, 0);
         write_out = 1'b1;
         tick();
         write_out = 1'b0;
         check("drop_overrun", ctrl_overrun, 1);
         check("drop_start",   aes_start,    0);
         check("drop_err",     ctr_error,    1);
         $display("block dropped (counter exhausted) pt=%h", pt);
         return;
      end
      if (k != m_key || nc != m_nonce || d != m_dest) m_n = 0;
      m_key = k; m_nonce = nc; m_dest = d;
      eblk  = exp_block(nc, m_n);
      eaddr = exp_addr(d, m_n);
      edata = pt ^ ks;
      check("ready_pre", ctrl_ready, 1);
      write_out = 1'b1;
      tick();
      write_out = 1'b0;
      key = rand128(); nonce = rand128(); destination = $urandom; plain_text = rand128();
      check("start",     aes_start,    1);
      check("blk_in",    aes_block_in, eblk);
      check("aes_key",   aes_key,      k);
      check("ready_busy", ctrl_ready,  0);
      tick();
      check("start_once", aes_start, 0);
      for (int i = 0; i < lat; i++) begin
         if (inject && i == 0) write_out = 1'b1;
         tick();
         write_out = 1'b0;
         if (inject && i == 0) check("overrun", ctrl_overrun, 1);
         check("wait_push",  fifo_push,    0);
         check("wait_blkin", aes_block_in, eblk);
      end
      aes_done = 1'b1; aes_block_out = ks; fifo_full = (full_cyc > 0);
      tick();
      aes_done = 1'b0; aes_block_out = rand128();
      for (int j = 0; j < full_cyc; j++) begin
         check("stall_push", fifo_push, 0);
         check("stall_data", fifo_data, edata);
         check("stall_addr", fifo_addr, eaddr);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      check("push",      fifo_push, 1);
      check("push_data", fifo_data, edata);
      check("push_addr", fifo_addr, eaddr);
      tick();
`ifdef CTR_WRAP_CHECK_EN
      if (m_n == (1 << TB_CTR_W) - 1) m_err = 1'b1;
`endif
      m_n    = (m_n + 1) % (1 << TB_CTR_W);
      m_data = edata;
      check("push_once",  fifo_push,  0);
      check("ready_post", ctrl_ready, !m_err);
      check("ctr_error",  ctr_error,  m_err);
      $display("block pushed blk_in=%h data=%h addr=%h lat=%0d stall=%0d ovr=%0d",
               eblk, edata, eaddr, lat, full_cyc, inject);
   endtask

   task automatic stray_done();
      aes_done = 1'b1; aes_block_out = rand128();
      tick();
      aes_done = 1'b0;
      check("stray_push",  fifo_push,  0);
      check("stray_start", aes_start,  0);
      check("stray_data",  fifo_data,  m_data);
      check("stray_ready", ctrl_ready, !m_err);
      $display("stray aes_done in IDLE ignored");
   endtask

   initial begin
      logic [127:0] k1, n1, n2, p1, ones;
      logic [31:0]  d1;
      HRESETn = 1'b0; write_out = 1'b0; aes_done = 1'b0; fifo_full = 1'b0;
      key = '0; nonce = '0; destination = '0; plain_text = '0; aes_block_out = '0;
      model_reset();
      tick();
      HRESETn = 1'b1;
      check_reset_outputs("init");
      $display("initial reset checked");

      k1   = 128'h44444444_33333333_22222222_11111111;
      n1   = 128'h45678900_34567890_23456789_12345678;
      d1   = 32'h10101010;
      p1   = 128'h4_00000003_00000002_00000001;
      ones = '1;

      run_block(k1, n1, d1, p1, 3, 0, 1'b0, ones);
      check("first_blk_is_nonce", exp_block(n1, 0), n1);
      run_block(k1, n1, d1, p1, 2, 3, 1'b0, ones);
      run_block(k1, n1, 32'h2000_0000, p1, 2, 0, 1'b1, rand128());
      stray_done();

      n2 = {n1[127:32], 32'hFFFF_FFFF};
      for (int b = 0; b < 5; b++) begin
         run_block(k1, n2, d1, rand128(), 1, 0, 1'b0, rand128());
      end

      // Reset while the AES core is busy: block abandoned, late done ignored.
      key = k1; nonce = n1; destination = d1; plain_text = p1;
      write_out = 1'b1;
      tick();
      write_out = 1'b0;
      tick();
      do_reset();
      aes_done = 1'b1; aes_block_out = rand128();
      tick();
      aes_done = 1'b0;
      check("late_done_push", fifo_push, 0);
      check("late_done_data", fifo_data, 0);
      check("late_done_ready", ctrl_ready, 1);

      for (int c = 0; c < 3; c++) begin
         cfg_key[c] = rand128(); cfg_nonce[c] = rand128(); cfg_dest[c] = $urandom;
      end
      for (int r = 0; r < 40; r++) begin
         int c;
         c = $urandom_range(0, 2);
         run_block(cfg_key[c], cfg_nonce[c], cfg_dest[c], rand128(), $urandom_range(0, 4),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0), rand128());
         if ($urandom_range(0, 4) == 0) stray_done();
         if (m_err && $urandom_range(0, 1) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
